dcache_sram_ctrl: RTL and testbench
===================================

Name: dcache_sram_ctrl

Overview:
- Single-clock access controller that drives one 512x32 byte-enabled simple dual-port data-cache SRAM way from its write and read ports.
- Arbitrates between CPU-side load/store requests and line refill beats arriving from the memory side.
- Returns load data with fixed 1-cycle latency, because the SRAM read is registered with no output register.
- Sits between the dcache tag/miss logic and the SRAM macro instance.

Parameters:
ADDR_W, 9, SRAM word-address width
DATA_W, 32, SRAM data width
BE_W, 4, byte-enable width (DATA_W/8)
LINE_LOG2, 3, log2 words per cache line (8 words/line)

Ports:
clk  in  1  single clock; drives both SRAM wr_clk and rd_clk
rst_n  in  1  synchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  CPU request accepted when valid&ready
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
req_be  in  BE_W  store byte enables
rsp_valid  out  1  load data valid
rsp_rdata  out  DATA_W  load data
refill_start  in  1  begin line refill (1-cycle pulse)
refill_line  in  ADDR_W-LINE_LOG2  line index to refill
refill_valid  in  1  refill beat valid
refill_ready  out  1  refill beat accepted when valid&ready
refill_data  in  DATA_W  refill beat data
refill_busy  out  1  refill in progress
refill_done  out  1  1-cycle pulse after last beat written
sram_wr_addr  out  ADDR_W  to SRAM wr_addr
sram_wr_data  out  DATA_W  to SRAM wr_data
sram_wr_en  out  1  to SRAM wr_en
sram_wr_byte_en  out  BE_W  to SRAM wr_byte_en
sram_rd_addr  out  ADDR_W  to SRAM rd_addr
sram_rd_data  in  DATA_W  from SRAM rd_data
sram_rst  out  1  to SRAM wr_rst/rd_rst (= ~rst_n)

Behaviour:
- FSM states: IDLE, FILL, DONE. Reset (rst_n=0 at clk edge) -> IDLE.
- Reset values: beat count 0; rsp_valid, refill_busy and refill_done all 0.
- IDLE -> FILL on refill_start. Latch refill_line; beat count := 0.
- FILL -> DONE on the accepted beat with count == 2^LINE_LOG2-1.
- DONE -> IDLE unconditionally. refill_done=1 only in DONE.
- refill_busy = (state != IDLE).
- req_ready = (state==IDLE) & ~refill_start. A refill_start arriving in the same cycle as a CPU request wins; the request stalls.
- refill_ready = (state==FILL). Beats are accepted at arbitrary spacing.
- Accepted beat, all combinational on SRAM ports:
  - sram_wr_en=1
  - sram_wr_addr={line, count}
  - sram_wr_byte_en=all ones
  - sram_wr_data=refill_data
  - count increments.
- Accepted store, combinational:
  - sram_wr_en=1
  - sram_wr_addr=req_addr
  - sram_wr_data=req_wdata
  - sram_wr_byte_en=req_be
  - No response.
  - req_be=0 still asserts wr_en (no-op write).
- Accepted load:
  - sram_rd_addr=req_addr in the same cycle.
  - rsp_valid=1 exactly next cycle.
  - rsp_rdata=sram_rd_data, passed through combinationally, valid only while rsp_valid.
- sram_wr_en=0 otherwise. sram_rd_addr holds its last value when idle.
- No read/write same-address collision is possible: one CPU op per cycle, CPU stalled during FILL.
- Store at cycle N followed by load of the same address at N+1 returns the new data. No bypass is needed.
- A load accepted in the cycle before refill_start still returns its response in the following cycle.
- Reset mid-FILL:
  - Return to IDLE, count 0, no refill_done.
  - Partially written line contents are undefined; tag logic must not mark the line valid.
- refill_start during FILL/DONE is ignored. refill_valid outside FILL is ignored.

Decomposition:
- Shared package dcache_pkg holds:
  - ADDR_W, DATA_W, BE_W, LINE_LOG2
  - derived LINE_W = ADDR_W-LINE_LOG2
  - FSM state enum {IDLE, FILL, DONE}
- No sub-module. The SRAM macro is instantiated by the parent way wrapper, not inside this block.

Test Plan:
- Reset: hold rst_n=0 3 cycles -> rsp_valid=0, refill_busy=0, refill_done=0, sram_wr_en=0, req_ready=1.
- Store/load: store addr 0x005 data 0xDEADBEEF be 4'b1111; then store same addr data 0x00000011 be 4'b0001; load 0x005 -> rsp_valid next cycle, rsp_rdata=0xDEADBE11.
- Refill line 3: 8 back-to-back beats 0x100..0x107 -> SRAM writes at addresses 0x018..0x01F; refill_done one cycle after beat 8; loads of 0x018/0x01F return 0x100/0x107.
- Gapped refill with stall: beats with idle gaps, req_valid held high throughout -> req_ready=0 from start cycle through DONE; load accepted first cycle back in IDLE.
- Simultaneous refill_start and load in IDLE -> refill starts, load stalled until after DONE, then answered with 1-cycle latency.
- Reset after 4th beat of line 7 -> IDLE next cycle, no refill_done; new refill of line 7 writes from 0x038.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry and refill FSM state for the dcache SRAM way controller
package dcache_pkg;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int BE_W = DATA_W / 8;
    localparam int LINE_LOG2 = 3;
    localparam int LINE_W = ADDR_W - LINE_LOG2;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
endpackage

// File: rtl/dcache_sram_ctrl.sv
// dcache_sram_ctrl: arbitrates CPU loads/stores and line refill beats onto one dual-port SRAM way
module dcache_sram_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              refill_start,
    input  logic [LINE_W-1:0] refill_line,
    input  logic              refill_valid,
    output logic              refill_ready,
    input  logic [DATA_W-1:0] refill_data,
    output logic              refill_busy,
    output logic              refill_done,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic              sram_wr_en,
    output logic [BE_W-1:0]   sram_wr_byte_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              sram_rst
);
    state_t                state;
    logic [LINE_W-1:0]     line;
    logic [LINE_LOG2-1:0]  cnt;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic                  beat;
    logic                  st;
    logic                  ld;
    // Handshakes and SRAM port steering; refill beats and stores never overlap since stores need IDLE
    always_comb begin
        req_ready       = (state == IDLE) && !refill_start;
        refill_ready    = (state == FILL);
        refill_busy     = (state != IDLE);
        refill_done     = (state == DONE);
        beat            = refill_ready && refill_valid;
        st              = req_valid && req_ready && req_we;
        ld              = req_valid && req_ready && !req_we;
        sram_wr_en      = beat || st;
        sram_wr_addr    = beat ? {line, cnt} : req_addr;
        sram_wr_data    = beat ? refill_data : req_wdata;
        sram_wr_byte_en = beat ? {BE_W{1'b1}} : req_be;
        sram_rd_addr    = ld ? req_addr : rd_addr_q;
        rsp_rdata       = sram_rd_data;
        sram_rst        = !rst_n;
    end
    // Refill FSM, beat counter and one-cycle load response tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            line      <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rsp_valid <= ld;
            if (ld) rd_addr_q <= req_addr;
            case (state)
                IDLE: if (refill_start) begin
                    state <= FILL;
                    line  <= refill_line;
                    cnt   <= '0;
                end
                FILL: if (refill_valid) begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_sram_ctrl.sv
// tb_dcache_sram_ctrl: scoreboard bench with a behavioural SRAM way behind the controller
module tb_dcache_sram_ctrl;
    import dcache_pkg::*;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [BE_W-1:0]   req_be = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              refill_start = 1'b0;
    logic [LINE_W-1:0] refill_line = '0;
    logic              refill_valid = 1'b0;
    logic              refill_ready;
    logic [DATA_W-1:0] refill_data = '0;
    logic              refill_busy;
    logic              refill_done;
    logic [ADDR_W-1:0] sram_wr_addr;
    logic [DATA_W-1:0] sram_wr_data;
    logic              sram_wr_en;
    logic [BE_W-1:0]   sram_wr_byte_en;
    logic [ADDR_W-1:0] sram_rd_addr;
    logic [DATA_W-1:0] sram_rd_data;
    logic              sram_rst;
    int                checks = 0;
    int                failures = 0;
    logic [DATA_W-1:0] sram_mem [512];
    logic [DATA_W-1:0] ref_mem [512];
    logic [DATA_W-1:0] exp_q [$];
    logic              ld_now = 1'b0;
    logic              exp_v = 1'b0;

    dcache_sram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .refill_start(refill_start), .refill_line(refill_line),
        .refill_valid(refill_valid), .refill_ready(refill_ready),
        .refill_data(refill_data), .refill_busy(refill_busy), .refill_done(refill_done),
        .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data), .sram_wr_en(sram_wr_en),
        .sram_wr_byte_en(sram_wr_byte_en), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .sram_rst(sram_rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_wr_en)
            for (int i = 0; i < BE_W; i++)
                if (sram_wr_byte_en[i]) sram_mem[sram_wr_addr][8*i +: 8] <= sram_wr_data[8*i +: 8];
        sram_rd_data <= sram_mem[sram_rd_addr];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_v = 1'b0;
            exp_q.delete();
        end else begin
            checks++;
            if (rsp_valid !== exp_v) begin
                failures++;
                $display("FAIL rsp_valid_timing got=%b exp=%b t=%0t", rsp_valid, exp_v, $time);
            end else if (exp_v && exp_q.size() > 0) begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rsp_rdata !== e) begin
                    failures++;
                    $display("FAIL rsp_rdata got=%h exp=%h t=%0t", rsp_rdata, e, $time);
                end
            end
            exp_v = ld_now;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        @(negedge clk);
        checks++;
        if ({req_ready, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en} !== {2'b11, a, d, be}) begin
            failures++;
            $display("FAIL store_port got=%b%b %h %h %b exp=11 %h %h %b", req_ready, sram_wr_en,
                     sram_wr_addr, sram_wr_data, sram_wr_byte_en, a, d, be);
        end
        for (int i = 0; i < BE_W; i++) if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        ld_now = 1'b1;
        exp_q.push_back(ref_mem[a]);
        @(negedge clk);
        checks++;
        if ({req_ready, sram_wr_en, sram_rd_addr} !== {2'b10, a}) begin
            failures++;
            $display("FAIL load_port got=%b%b %h exp=10 %h", req_ready, sram_wr_en, sram_rd_addr, a);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; ld_now = 1'b0;
    endtask

    task automatic do_refill(input logic [LINE_W-1:0] ln, input logic [DATA_W-1:0] base, input bit gap,
                             input int abort_at, input bit hold_ld, input logic [ADDR_W-1:0] ld_addr);
        refill_start = 1'b1; refill_line = ln;
        if (hold_ld) begin req_valid = 1'b1; req_we = 1'b0; req_addr = ld_addr; end
        @(negedge clk);
        checks++;
        if ({req_ready, sram_wr_en, refill_busy, refill_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL refill_start_cycle got=%b exp=0000", {req_ready, sram_wr_en, refill_busy, refill_ready});
        end
        @(posedge clk); #1;
        refill_start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b == abort_at) begin
                rst_n = 1'b0; refill_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                checks++;
                if ({refill_busy, refill_done, refill_ready, req_ready} !== 4'b0001) begin
                    failures++;
                    $display("FAIL abort_idle got=%b exp=0001", {refill_busy, refill_done, refill_ready, req_ready});
                end
                @(posedge clk); #1;
                @(negedge clk);
                checks++;
                if (refill_done !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_no_done got=%b exp=0", refill_done);
                end
                @(posedge clk); #1;
                return;
            end
            repeat (gap ? b % 3 : 0) begin
                refill_valid = 1'b0; refill_start = 1'b1; refill_line = '0;
                @(negedge clk);
                checks++;
                if ({req_ready, refill_ready, refill_busy, sram_wr_en} !== 4'b0110) begin
                    failures++;
                    $display("FAIL gap_cycle got=%b exp=0110", {req_ready, refill_ready, refill_busy, sram_wr_en});
                end
                @(posedge clk); #1;
            end
            refill_start = 1'b0; refill_valid = 1'b1; refill_data = base + DATA_W'(b);
            @(negedge clk);
            checks++;
            if ({refill_ready, req_ready, sram_wr_en, sram_wr_addr, sram_wr_byte_en, sram_wr_data} !==
                {3'b101, ln, 3'(b), 4'hf, base + DATA_W'(b)}) begin
                failures++;
                $display("FAIL beat%0d got=%b%b%b %h %b %h exp=101 %h 1111 %h", b, refill_ready, req_ready,
                         sram_wr_en, sram_wr_addr, sram_wr_byte_en, sram_wr_data, {ln, 3'(b)}, base + DATA_W'(b));
            end
            ref_mem[{ln, 3'(b)}] = base + DATA_W'(b);
            @(posedge clk); #1;
        end
        refill_valid = 1'b1; refill_data = 32'hBAD0BAD0;
        @(negedge clk);
        checks++;
        if ({refill_done, refill_busy, req_ready, sram_wr_en, refill_ready} !== 5'b11000) begin
            failures++;
            $display("FAIL done_cycle got=%b exp=11000", {refill_done, refill_busy, req_ready, sram_wr_en, refill_ready});
        end
        @(posedge clk); #1;
        refill_valid = 1'b0;
        if (hold_ld) begin
            ld_now = 1'b1;
            exp_q.push_back(ref_mem[ld_addr]);
        end
        @(negedge clk);
        checks++;
        if ({refill_done, refill_busy, req_ready} !== 3'b001 || (hold_ld && sram_rd_addr !== ld_addr)) begin
            failures++;
            $display("FAIL back_to_idle got=%b rd=%h exp=001 rd=%h", {refill_done, refill_busy, req_ready},
                     sram_rd_addr, ld_addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; ld_now = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, refill_busy, refill_done, sram_wr_en, req_ready, sram_rst} !== 6'b000011) begin
            failures++;
            $display("FAIL reset_state got=%b exp=000011",
                     {rsp_valid, refill_busy, refill_done, sram_wr_en, req_ready, sram_rst});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        do_store(9'h005, 32'hDEADBEEF, 4'b1111);
        do_store(9'h005, 32'h00000011, 4'b0001);
        do_load(9'h005);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_rdata, sram_rd_addr} !== {1'b1, 32'hDEADBE11, 9'h005}) begin
            failures++;
            $display("FAIL store_merge got=%b %h rd=%h exp=1 deadbe11 rd=005", rsp_valid, rsp_rdata, sram_rd_addr);
        end
        @(posedge clk); #1;
        do_store(9'h005, 32'hFFFFFFFF, 4'b0000);
        do_load(9'h005);
        do_store(9'h1FF, 32'h12345678, 4'b1111);
        do_load(9'h1FF);
        do_load(9'h000);
    endtask

    task automatic test_refill();
        do_refill(6'd3, 32'h100, 1'b0, 8, 1'b0, '0);
        do_load(9'h018);
        do_load(9'h01F);
        do_load(9'h01A);
    endtask

    task automatic test_gapped_stall();
        do_refill(6'd5, 32'h200, 1'b1, 8, 1'b1, 9'h02B);
        do_load(9'h028);
    endtask

    task automatic test_back_to_back();
        do_load(9'h01F);
        do_refill(6'd4, 32'h300, 1'b0, 8, 1'b1, 9'h018);
        do_load(9'h027);
    endtask

    task automatic test_reset_mid_fill();
        do_refill(6'd7, 32'h400, 1'b0, 4, 1'b0, '0);
        do_refill(6'd7, 32'h500, 1'b0, 8, 1'b0, '0);
        do_load(9'h038);
        do_load(9'h03F);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_refill();
        test_gapped_stall();
        test_back_to_back();
        test_reset_mid_fill();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
